// File: rtl/load_ext_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_ext_pipe_pkg
// Description : Shared load-size encodings and parameter legality helpers for
//               the MEM->WB load aligner/extender pipeline.
// Revision    : 1.0  initial release
// ============================================================================
package load_ext_pipe_pkg;

    // Load access size as carried on the in_size field.
    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    // Only 32- and 64-bit datapaths are supported.
    function automatic bit data_w_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

    // Pipeline depth must stay within 1..4 register stages.
    function automatic bit stages_legal(input int s);
        return (s >= 1) && (s <= 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_ext_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : load_ext_pipe_if
// Description : Valid/ready bus between the memory read stage, the load
//               aligner pipeline and the writeback stage.
// Revision    : 1.0  initial release
// ============================================================================
interface load_ext_pipe_if
    import load_ext_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 16
);
    localparam int c_AL = $clog2(DATA_W / 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_word;
    logic [c_AL-1:0]      in_addr_lo;
    size_e                in_size;
    logic                 in_sext;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    // Upstream/downstream environment side.
    modport master (
        output in_valid, in_word, in_addr_lo, in_size, in_sext, out_ready,
        input  in_ready, out_valid, out_data, out_err, err_count
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_word, in_addr_lo, in_size, in_sext, out_ready,
        output in_ready, out_valid, out_data, out_err, err_count
    );

endinterface
`default_nettype wire

// File: rtl/load_ext_pipe_lane_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext_pipe_lane_ext
// Description : Combinational little-endian lane select, zero/sign extension
//               and misalignment/illegal-size detection for one load beat.
// Revision    : 1.0  initial release
// ============================================================================
module load_ext_pipe_lane_ext
    import load_ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic [DATA_W-1:0]              i_word,
    input  logic [$clog2(DATA_W/8)-1:0]    i_addr_lo,
    input  size_e                          i_size,
    input  logic                           i_sext,
    output logic [DATA_W-1:0]              o_data,
    output logic                           o_err
);
    localparam int c_IDX_W = $clog2(DATA_W);

    logic [DATA_W-1:0]  w_lane;
    logic [DATA_W-1:0]  w_mask;
    logic [c_IDX_W-1:0] w_msb_idx;
    logic               w_fill;

    // Shift the addressed byte to bit 0, keep the field, fill above its MSB.
    // When the field spans the whole word the mask is all ones, so the fill
    // bit has no effect and sign/zero extension collapse to a pass-through.
    always_comb begin
        w_lane    = i_word >> {i_addr_lo, 3'b000};
        o_err     = 1'b0;
        w_msb_idx = c_IDX_W'(7);
        unique case (i_size)
            SZ_BYTE: w_msb_idx = c_IDX_W'(7);
            SZ_HALF: begin
                w_msb_idx = c_IDX_W'(15);
                o_err     = i_addr_lo[0];
            end
            SZ_WORD: begin
                w_msb_idx = c_IDX_W'(31);
                o_err     = |i_addr_lo[1:0];
            end
            default: begin
                // A dword cannot be formed on a 32-bit datapath at all.
                w_msb_idx = c_IDX_W'(DATA_W - 1);
                o_err     = (DATA_W != 64) || (|i_addr_lo);
            end
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            w_mask[i] = (c_IDX_W'(i) <= w_msb_idx);
        end
        w_fill = i_sext & w_lane[w_msb_idx];
        o_data = o_err ? '0 : ((w_lane & w_mask) | ({DATA_W{w_fill}} & ~w_mask));
    end

endmodule
`default_nettype wire

// File: rtl/load_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : load_ext_pipe
// Description : Pipelined load-data aligner/extender for the MEM->WB path with
//               valid/ready handshake, global stall and a saturating count of
//               erroneous loads.
// Revision    : 1.0  initial release
// ============================================================================
module load_ext_pipe
    import load_ext_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int STAGES    = 1,
    parameter int ERR_CNT_W = 16
)(
    input  logic           clk,
    input  logic           rst,
    load_ext_pipe_if.slave bus
);
    // Reject unsupported configurations at elaboration time.
    if (!data_w_legal(DATA_W) || !stages_legal(STAGES)) begin : g_param_check
        $error("load_ext_pipe: DATA_W must be 32/64 and STAGES 1..4");
    end

    logic [DATA_W-1:0]    w_data;
    logic                 w_err;
    logic                 w_adv;
    logic                 w_accept;
    logic [STAGES:0]      w_valid_chain;
    logic [STAGES:0]      w_err_chain;
    logic [DATA_W-1:0]    w_data_chain [STAGES+1];
    logic [ERR_CNT_W-1:0] r_err_count;

    load_ext_pipe_lane_ext #(
        .DATA_W (DATA_W)
    ) u_lane_ext (
        .i_word    (bus.in_word),
        .i_addr_lo (bus.in_addr_lo),
        .i_size    (bus.in_size),
        .i_sext    (bus.in_sext),
        .o_data    (w_data),
        .o_err     (w_err)
    );

    // The whole pipe moves as one unit: it advances unless the last stage
    // holds a result that downstream is refusing.
    assign w_adv    = !w_valid_chain[STAGES] || bus.out_ready;
    assign w_accept = bus.in_valid && w_adv;

    assign w_valid_chain[0] = bus.in_valid;
    assign w_err_chain[0]   = w_err;
    assign w_data_chain[0]  = w_data;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic              r_valid;
        logic              r_err;
        logic [DATA_W-1:0] r_data;

        // Stage register: shifts beats and bubbles alike, holds on stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_data  <= '0;
            end else if (w_adv) begin
                r_valid <= w_valid_chain[s];
                r_err   <= w_err_chain[s];
                r_data  <= w_data_chain[s];
            end
        end

        assign w_valid_chain[s+1] = r_valid;
        assign w_err_chain[s+1]   = r_err;
        assign w_data_chain[s+1]  = r_data;
    end

    // Count erroneous loads when they enter the pipe; stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_accept && w_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = w_valid_chain[STAGES];
    assign bus.out_data  = w_data_chain[STAGES];
    assign bus.out_err   = w_err_chain[STAGES];
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_load_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_ext_pipe
// Description : Directed self-checking bench for load_ext_pipe: a 32-bit
//               single-stage instance, a 32-bit three-stage instance with a
//               4-bit error counter, and a 64-bit two-stage instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_load_ext_pipe;
    import load_ext_pipe_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    load_ext_pipe_if #(.DATA_W(32), .ERR_CNT_W(16)) a_if ();
    load_ext_pipe_if #(.DATA_W(32), .ERR_CNT_W(4))  b_if ();
    load_ext_pipe_if #(.DATA_W(64), .ERR_CNT_W(16)) c_if ();

    load_ext_pipe #(.DATA_W(32), .STAGES(1), .ERR_CNT_W(16)) dut_a (
        .clk (clk), .rst (rst), .bus (a_if.slave)
    );
    load_ext_pipe #(.DATA_W(32), .STAGES(3), .ERR_CNT_W(4)) dut_b (
        .clk (clk), .rst (rst), .bus (b_if.slave)
    );
    load_ext_pipe #(.DATA_W(64), .STAGES(2), .ERR_CNT_W(16)) dut_c (
        .clk (clk), .rst (rst), .bus (c_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b want 0", a_if.out_valid); end
        checks++; if (a_if.out_data !== 32'h0) begin errors++; $display("FAIL reset_a_data: got %h want 0", a_if.out_data); end
        checks++; if (a_if.out_err !== 1'b0) begin errors++; $display("FAIL reset_a_err: got %b want 0", a_if.out_err); end
        checks++; if (a_if.err_count !== 16'd0) begin errors++; $display("FAIL reset_a_cnt: got %0d want 0", a_if.err_count); end
        checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b want 1", a_if.in_ready); end
        checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", b_if.out_valid); end
        checks++; if (b_if.err_count !== 4'd0) begin errors++; $display("FAIL reset_b_cnt: got %0d want 0", b_if.err_count); end
        checks++; if (c_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %b want 0", c_if.out_valid); end
        rst = 1'b0;
    endtask

    // Single-stage 32-bit: one beat, result one cycle later.
    task automatic test_extend();
        size_e       sz   [9];
        logic [1:0]  ad   [9];
        logic        sx   [9];
        logic [31:0] exp  [9];
        sz  = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE, SZ_WORD, SZ_HALF, SZ_BYTE};
        ad  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd2};
        sx  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp = '{32'h0000007F, 32'hFFFFFFFF, 32'h000080FF, 32'hFFFF80FF, 32'h00000080,
                32'hFFFFFF80, 32'h80FF7F01, 32'h00007F01, 32'h000000FF};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a_if.in_valid   = 1'b1;
            a_if.in_word    = 32'h80FF7F01;
            a_if.in_size    = sz[i];
            a_if.in_addr_lo = ad[i];
            a_if.in_sext    = sx[i];
            @(negedge clk);
            a_if.in_valid = 1'b0;
            #1;
            checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL ext_valid[%0d]: got %b want 1", i, a_if.out_valid); end
            checks++; if (a_if.out_data !== exp[i]) begin errors++; $display("FAIL ext_data[%0d]: got %h want %h", i, a_if.out_data, exp[i]); end
            checks++; if (a_if.out_err !== 1'b0) begin errors++; $display("FAIL ext_err[%0d]: got %b want 0", i, a_if.out_err); end
        end
    endtask

    // Misaligned half, misaligned word, dword on a 32-bit datapath.
    task automatic test_errors();
        size_e      sz [3];
        logic [1:0] ad [3];
        sz = '{SZ_HALF, SZ_WORD, SZ_DWORD};
        ad = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_if.in_valid   = 1'b1;
            a_if.in_word    = 32'h80FF7F01;
            a_if.in_size    = sz[i];
            a_if.in_addr_lo = ad[i];
            a_if.in_sext    = 1'b1;
            @(negedge clk);
            a_if.in_valid = 1'b0;
            #1;
            checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL err_valid[%0d]: got %b want 1", i, a_if.out_valid); end
            checks++; if (a_if.out_data !== 32'h0) begin errors++; $display("FAIL err_data[%0d]: got %h want 0", i, a_if.out_data); end
            checks++; if (a_if.out_err !== 1'b1) begin errors++; $display("FAIL err_flag[%0d]: got %b want 1", i, a_if.out_err); end
        end
        checks++; if (a_if.err_count !== 16'd3) begin errors++; $display("FAIL err_count_a: got %0d want 3", a_if.err_count); end
    endtask

    // Two-stage 64-bit instance: dword path and wide extension.
    task automatic test_wide64();
        size_e       sz   [8];
        logic [2:0]  ad   [8];
        logic        sx   [8];
        logic [63:0] exp  [8];
        logic        ee   [8];
        sz  = '{SZ_DWORD, SZ_WORD, SZ_WORD, SZ_HALF, SZ_BYTE, SZ_DWORD, SZ_WORD, SZ_HALF};
        ad  = '{3'd0, 3'd4, 3'd4, 3'd6, 3'd1, 3'd4, 3'd2, 3'd3};
        sx  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp = '{64'h800000FF1234F678, 64'hFFFFFFFF800000FF, 64'h00000000800000FF,
                64'hFFFFFFFFFFFF8000, 64'hFFFFFFFFFFFFFFF6, 64'h0, 64'h0, 64'h0};
        ee  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            c_if.in_valid   = 1'b1;
            c_if.in_word    = 64'h800000FF1234F678;
            c_if.in_size    = sz[i];
            c_if.in_addr_lo = ad[i];
            c_if.in_sext    = sx[i];
            @(negedge clk);
            c_if.in_valid = 1'b0;
            #1;
            checks++; if (c_if.out_valid !== 1'b0) begin errors++; $display("FAIL w64_early[%0d]: got %b want 0", i, c_if.out_valid); end
            @(negedge clk);
            #1;
            checks++; if (c_if.out_valid !== 1'b1) begin errors++; $display("FAIL w64_valid[%0d]: got %b want 1", i, c_if.out_valid); end
            checks++; if (c_if.out_data !== exp[i]) begin errors++; $display("FAIL w64_data[%0d]: got %h want %h", i, c_if.out_data, exp[i]); end
            checks++; if (c_if.out_err !== ee[i]) begin errors++; $display("FAIL w64_err[%0d]: got %b want %b", i, c_if.out_err, ee[i]); end
        end
        checks++; if (c_if.err_count !== 16'd3) begin errors++; $display("FAIL err_count_c: got %0d want 3", c_if.err_count); end
    endtask

    // Three-stage pipe, five consecutive beats, downstream always ready.
    task automatic test_back_to_back();
        logic        ev;
        logic [31:0] ed;
        b_if.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ev = (c >= 3) && (c <= 7);
            ed = 32'hA0000000 + 32'(c - 3);
            checks++; if (b_if.out_valid !== ev) begin errors++; $display("FAIL b2b_valid[c%0d]: got %b want %b", c, b_if.out_valid, ev); end
            if (ev) begin
                checks++; if (b_if.out_data !== ed) begin errors++; $display("FAIL b2b_data[c%0d]: got %h want %h", c, b_if.out_data, ed); end
            end
            if (c < 5) begin
                b_if.in_valid   = 1'b1;
                b_if.in_word    = 32'hA0000000 + 32'(c);
                b_if.in_size    = SZ_WORD;
                b_if.in_addr_lo = 2'd0;
                b_if.in_sext    = 1'b0;
            end else begin
                b_if.in_valid = 1'b0;
            end
        end
    endtask

    // Downstream stalls for four cycles mid-stream; scoreboard checks order.
    task automatic test_stall();
        logic [31:0] q [$];
        logic [31:0] held;
        logic [31:0] want;
        bit          holding;
        int          sent;
        int          rcvd;
        holding = 1'b0;
        held    = '0;
        sent    = 0;
        rcvd    = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            b_if.out_ready = !(c >= 5 && c < 9);
            if (sent < 6) begin
                b_if.in_valid   = 1'b1;
                b_if.in_word    = {16'h8000 + 16'(sent), 16'h1234};
                b_if.in_size    = SZ_HALF;
                b_if.in_addr_lo = 2'd2;
                b_if.in_sext    = 1'b1;
            end else begin
                b_if.in_valid = 1'b0;
            end
            #1;
            if (holding) begin
                checks++; if (b_if.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid[c%0d]: got %b want 1", c, b_if.out_valid); end
                checks++; if (b_if.out_data !== held) begin errors++; $display("FAIL stall_hold_data[c%0d]: got %h want %h", c, b_if.out_data, held); end
            end
            if (b_if.out_valid && !b_if.out_ready) begin
                checks++; if (b_if.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[c%0d]: got %b want 0", c, b_if.in_ready); end
            end
            if (b_if.out_valid && b_if.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stall_extra[c%0d]: got beat %h want none", c, b_if.out_data);
                end else begin
                    want = q.pop_front();
                    if (b_if.out_data !== want) begin errors++; $display("FAIL stall_data[c%0d]: got %h want %h", c, b_if.out_data, want); end
                end
                rcvd++;
            end
            if (b_if.in_valid && b_if.in_ready) begin
                q.push_back(32'hFFFF8000 + 32'(sent));
                sent++;
            end
            holding = b_if.out_valid && !b_if.out_ready;
            held    = b_if.out_data;
        end
        b_if.out_ready = 1'b1;
        checks++; if (rcvd !== 6) begin errors++; $display("FAIL stall_count: got %0d want 6", rcvd); end
    endtask

    // Reset with two beats in flight (one erroneous) flushes everything.
    task automatic test_reset_flush();
        b_if.out_ready = 1'b1;
        @(negedge clk);
        b_if.in_valid   = 1'b1;
        b_if.in_word    = 32'h11111111;
        b_if.in_size    = SZ_WORD;
        b_if.in_addr_lo = 2'd0;
        b_if.in_sext    = 1'b0;
        @(negedge clk);
        b_if.in_size    = SZ_HALF;
        b_if.in_addr_lo = 2'd1;
        @(negedge clk);
        b_if.in_valid = 1'b0;
        #1;
        checks++; if (b_if.err_count !== 4'd1) begin errors++; $display("FAIL flush_pre_cnt: got %0d want 1", b_if.err_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", b_if.out_valid); end
        checks++; if (b_if.err_count !== 4'd0) begin errors++; $display("FAIL flush_cnt: got %0d want 0", b_if.err_count); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale[c%0d]: got %b want 0", c, b_if.out_valid); end
        end
    endtask

    // Twenty misaligned beats into a 4-bit counter.
    task automatic test_saturate();
        b_if.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 14) begin
                checks++; if (b_if.err_count !== 4'd14) begin errors++; $display("FAIL sat_cnt14: got %0d want 14", b_if.err_count); end
            end
            if (k == 16) begin
                checks++; if (b_if.err_count !== 4'd15) begin errors++; $display("FAIL sat_cnt16: got %0d want 15", b_if.err_count); end
            end
            if (k == 10) begin
                checks++; if (b_if.out_valid !== 1'b1) begin errors++; $display("FAIL sat_out_valid: got %b want 1", b_if.out_valid); end
                checks++; if (b_if.out_err !== 1'b1) begin errors++; $display("FAIL sat_out_err: got %b want 1", b_if.out_err); end
                checks++; if (b_if.out_data !== 32'h0) begin errors++; $display("FAIL sat_out_data: got %h want 0", b_if.out_data); end
            end
            b_if.in_valid   = 1'b1;
            b_if.in_word    = 32'hDEADBEEF;
            b_if.in_size    = SZ_HALF;
            b_if.in_addr_lo = 2'd1;
            b_if.in_sext    = 1'b0;
        end
        @(negedge clk);
        b_if.in_valid = 1'b0;
        #1;
        checks++; if (b_if.err_count !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d want 15", b_if.err_count); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        a_if.in_valid = 1'b0; a_if.in_word = '0; a_if.in_addr_lo = '0;
        a_if.in_size  = SZ_BYTE; a_if.in_sext = 1'b0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_word = '0; b_if.in_addr_lo = '0;
        b_if.in_size  = SZ_BYTE; b_if.in_sext = 1'b0; b_if.out_ready = 1'b1;
        c_if.in_valid = 1'b0; c_if.in_word = '0; c_if.in_addr_lo = '0;
        c_if.in_size  = SZ_BYTE; c_if.in_sext = 1'b0; c_if.out_ready = 1'b1;

        test_reset();
        test_extend();
        test_errors();
        test_wide64();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_saturate();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
